// File: rtl/egress_wrr_sched_pkg.sv
// Shared definitions for the two-queue egress WRR scheduler.
// These cover the FIFO entry layout, the FSM encoding and the queue ids.
package egress_wrr_sched_pkg;

  localparam int DEFAULT_DATA_WIDTH = 256;
  localparam int DEFAULT_KEEP_WIDTH = 32;

  // Entry layout is {end, start, keep, data}, with data in the LSBs.
  localparam int DATA_LSB  = 0;
  localparam int KEEP_LSB  = DATA_LSB + DEFAULT_DATA_WIDTH;
  localparam int START_BIT = KEEP_LSB + DEFAULT_KEEP_WIDTH;
  localparam int END_BIT   = START_BIT + 1;

  function automatic int keep_lsb(input int dw);
    return DATA_LSB + dw;
  endfunction

  function automatic int start_bit(input int dw, input int kw);
    return DATA_LSB + dw + kw;
  endfunction

  function automatic int end_bit(input int dw, input int kw);
    return DATA_LSB + dw + kw + 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic Q_NIC = 1'b0;
  localparam logic Q_P2P = 1'b1;

endpackage

// File: rtl/egress_wrr_sched_wrr_arb2.sv
// Combinational two-way weighted round-robin grant with credit update.
// The caller commits the *_next values only when it actually takes the grant.
module wrr_arb2
  import egress_wrr_sched_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 8
) (
  input  logic [1:0]                   req,
  input  logic                         strict,
  input  logic                         last_grant,
  input  logic [1:0][WEIGHT_WIDTH-1:0] credit,
  input  logic [1:0][WEIGHT_WIDTH-1:0] weight,
  output logic                         grant_valid,
  output logic                         grant,
  output logic [1:0][WEIGHT_WIDTH-1:0] credit_next,
  output logic                         last_grant_next
);

  logic [1:0][WEIGHT_WIDTH-1:0] reload;
  logic                         cur_q;
  logic                         oth_q;

  assign cur_q = last_grant;
  assign oth_q = ~last_grant;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_reload
      // A weight of 0 behaves like 1, so the reload value is max(w,1)-1.
      assign reload[gi] = (weight[gi] == '0) ? '0 : weight[gi] - WEIGHT_WIDTH'(1);
    end
  endgenerate

  always_comb begin
    grant_valid     = 1'b0;
    grant           = Q_NIC;
    credit_next     = credit;
    last_grant_next = last_grant;
    if (strict) begin
      grant_valid = |req;
      grant       = req[Q_NIC] ? Q_NIC : Q_P2P;
    end else if (req[cur_q] && (credit[cur_q] != '0)) begin
      grant_valid        = 1'b1;
      grant              = cur_q;
      credit_next[cur_q] = credit[cur_q] - WEIGHT_WIDTH'(1);
    end else if (req[oth_q]) begin
      grant_valid        = 1'b1;
      grant              = oth_q;
      credit_next[oth_q] = reload[oth_q];
      last_grant_next    = oth_q;
    end else if (req[cur_q]) begin
      grant_valid        = 1'b1;
      grant              = cur_q;
      credit_next[cur_q] = reload[cur_q];
    end
  end

endmodule

// File: rtl/egress_wrr_sched.sv
// Packet-atomic WRR scheduler that merges the NIC and P2P egress FIFOs onto one TX stream.
// It holds the grant FSM, the registered output stage, the packet counters and the framing flag.
module egress_wrr_sched
  import egress_wrr_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int KEEP_WIDTH   = 32,
  parameter int ENTRY_WIDTH  = DATA_WIDTH + KEEP_WIDTH + 2,
  parameter int WEIGHT_WIDTH = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cfg_enable,
  input  logic                    i_cfg_strict,
  input  logic [WEIGHT_WIDTH-1:0] iv_cfg_weight_0,
  input  logic [WEIGHT_WIDTH-1:0] iv_cfg_weight_1,
  input  logic                    i_q0_empty,
  output logic                    o_q0_rd_en,
  input  logic [ENTRY_WIDTH-1:0]  iv_q0_dout,
  input  logic                    i_q1_empty,
  output logic                    o_q1_rd_en,
  input  logic [ENTRY_WIDTH-1:0]  iv_q1_dout,
  output logic                    o_tx_valid,
  output logic                    o_tx_start,
  output logic                    o_tx_end,
  output logic [KEEP_WIDTH-1:0]   ov_tx_keep,
  output logic [DATA_WIDTH-1:0]   ov_tx_data,
  input  logic                    i_tx_ready,
  output logic [CNT_WIDTH-1:0]    ov_q0_pkt_cnt,
  output logic [CNT_WIDTH-1:0]    ov_q1_pkt_cnt,
  output logic                    o_err_sticky,
  input  logic                    i_cnt_clear
);

  localparam int KEEP_LSB_I  = keep_lsb(DATA_WIDTH);
  localparam int START_BIT_I = start_bit(DATA_WIDTH, KEEP_WIDTH);
  localparam int END_BIT_I   = end_bit(DATA_WIDTH, KEEP_WIDTH);

  state_t                       state_reg, state_next;
  logic                         gnt_reg, gnt_next;
  logic                         last_grant_reg, last_grant_next;
  logic [1:0][WEIGHT_WIDTH-1:0] credit_reg, credit_next;
  logic                         first_beat_reg, first_beat_next;
  logic                         qid_reg;
  logic [1:0][CNT_WIDTH-1:0]    cnt_reg, cnt_next;

  logic                         arb_valid, arb_grant, arb_last_grant;
  logic [1:0][WEIGHT_WIDTH-1:0] arb_credit;

  logic [ENTRY_WIDTH-1:0] head;
  logic                   head_empty;
  logic                   head_start;
  logic                   head_end;
  logic                   pop;
  logic                   frame_err;
  logic                   tx_accept_end;

  assign head       = (gnt_reg == Q_P2P) ? iv_q1_dout : iv_q0_dout;
  assign head_empty = (gnt_reg == Q_P2P) ? i_q1_empty : i_q0_empty;
  assign head_start = head[START_BIT_I];
  assign head_end   = head[END_BIT_I];

  assign pop        = (state_reg == XFER) & ~head_empty & (~o_tx_valid | i_tx_ready);
  assign o_q0_rd_en = pop & (gnt_reg == Q_NIC);
  assign o_q1_rd_en = pop & (gnt_reg == Q_P2P);

  // Start must appear on the first beat of a grant and nowhere else.
  assign frame_err     = pop & (first_beat_reg ? ~head_start : head_start);
  assign tx_accept_end = o_tx_valid & i_tx_ready & o_tx_end;

  wrr_arb2 #(
    .WEIGHT_WIDTH(WEIGHT_WIDTH)
  ) u_arb (
    .req            ({~i_q1_empty, ~i_q0_empty}),
    .strict         (i_cfg_strict),
    .last_grant     (last_grant_reg),
    .credit         (credit_reg),
    .weight         ({iv_cfg_weight_1, iv_cfg_weight_0}),
    .grant_valid    (arb_valid),
    .grant          (arb_grant),
    .credit_next    (arb_credit),
    .last_grant_next(arb_last_grant)
  );

  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    last_grant_next = last_grant_reg;
    credit_next     = credit_reg;
    first_beat_next = first_beat_reg;
    case (state_reg)
      IDLE: begin
        if (i_cfg_enable && arb_valid) begin
          state_next      = XFER;
          gnt_next        = arb_grant;
          last_grant_next = arb_last_grant;
          credit_next     = arb_credit;
          first_beat_next = 1'b1;
        end
      end
      XFER: begin
        if (pop) begin
          first_beat_next = 1'b0;
          if (head_end) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_cnt
      // Clearing wins over a packet completing in the same cycle.
      assign cnt_next[gi] = i_cnt_clear ? '0 :
                            (tx_accept_end && (qid_reg == 1'(gi))) ? cnt_reg[gi] + CNT_WIDTH'(1) :
                            cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      gnt_reg        <= Q_NIC;
      last_grant_reg <= Q_P2P;
      credit_reg     <= '0;
      first_beat_reg <= 1'b0;
      o_tx_valid     <= 1'b0;
      o_tx_start     <= 1'b0;
      o_tx_end       <= 1'b0;
      ov_tx_keep     <= '0;
      ov_tx_data     <= '0;
      qid_reg        <= Q_NIC;
      cnt_reg        <= '0;
      o_err_sticky   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      last_grant_reg <= last_grant_next;
      credit_reg     <= credit_next;
      first_beat_reg <= first_beat_next;
      cnt_reg        <= cnt_next;
      if (pop) begin
        o_tx_valid <= 1'b1;
        o_tx_start <= head_start;
        o_tx_end   <= head_end;
        ov_tx_keep <= head[KEEP_LSB_I +: KEEP_WIDTH];
        ov_tx_data <= head[DATA_LSB +: DATA_WIDTH];
        qid_reg    <= gnt_reg;
      end else if (i_tx_ready) begin
        o_tx_valid <= 1'b0;
      end
      if (i_cnt_clear) begin
        o_err_sticky <= 1'b0;
      end else if (frame_err) begin
        o_err_sticky <= 1'b1;
      end
    end
  end

  assign ov_q0_pkt_cnt = cnt_reg[0];
  assign ov_q1_pkt_cnt = cnt_reg[1];

endmodule

// File: tb/tb_egress_wrr_sched.sv
// Directed bench for egress_wrr_sched: bench-side FWFT FIFO models feed the DUT.
// A negedge monitor logs every accepted beat for ordering, latency and stall checks.
module tb_egress_wrr_sched;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int EW = DW + KW + 2;
  localparam int WW = 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable, strict, ready, clear;
  logic [WW-1:0] w0, w1;
  logic          q0_empty, q1_empty, q0_rd, q1_rd;
  logic [EW-1:0] q0_dout, q1_dout;
  logic          tx_valid, tx_start, tx_end;
  logic [KW-1:0] tx_keep;
  logic [DW-1:0] tx_data;
  logic [CW-1:0] cnt0, cnt1;
  logic          sticky;

  always #5 clk = ~clk;

  egress_wrr_sched dut (
    .clk            (clk),
    .rst            (rst),
    .i_cfg_enable   (enable),
    .i_cfg_strict   (strict),
    .iv_cfg_weight_0(w0),
    .iv_cfg_weight_1(w1),
    .i_q0_empty     (q0_empty),
    .o_q0_rd_en     (q0_rd),
    .iv_q0_dout     (q0_dout),
    .i_q1_empty     (q1_empty),
    .o_q1_rd_en     (q1_rd),
    .iv_q1_dout     (q1_dout),
    .o_tx_valid     (tx_valid),
    .o_tx_start     (tx_start),
    .o_tx_end       (tx_end),
    .ov_tx_keep     (tx_keep),
    .ov_tx_data     (tx_data),
    .i_tx_ready     (ready),
    .ov_q0_pkt_cnt  (cnt0),
    .ov_q1_pkt_cnt  (cnt1),
    .o_err_sticky   (sticky),
    .i_cnt_clear    (clear)
  );

  // FWFT FIFO models: the write pointer belongs to the stimulus, the read pointer to the pop logic.
  logic [EW-1:0] q0_mem [64];
  logic [EW-1:0] q1_mem [64];
  int q0_wr = 0, q0_rp = 0, q1_wr = 0, q1_rp = 0;

  assign q0_empty = (q0_rp == q0_wr);
  assign q1_empty = (q1_rp == q1_wr);
  assign q0_dout  = q0_mem[q0_rp % 64];
  assign q1_dout  = q1_mem[q1_rp % 64];

  always @(posedge clk) begin
    if (q0_rd) q0_rp <= q0_rp + 1;
    if (q1_rd) q1_rp <= q1_rp + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change at posedge+1, so the negedge view predicts the next edge.
  int log_q   [256];
  int log_seq [256];
  int log_t   [256];
  int log_n   = 0;
  int rd_cnt  = 0;
  int both_rd = 0;

  always @(negedge clk) begin
    if (tx_valid && ready) begin
      log_q[log_n]   <= int'(tx_data[8]);
      log_seq[log_n] <= int'(tx_data[7:0]);
      log_t[log_n]   <= cyc;
      log_n          <= log_n + 1;
    end
    if (q0_rd || q1_rd) rd_cnt <= rd_cnt + 1;
    if (q0_rd && q1_rd) both_rd <= both_rd + 1;
  end

  int errs   = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic q, input logic [7:0] seq,
                                       input logic s, input logic e);
    logic [DW-1:0] d;
    d      = '0;
    d[8]   = q;
    d[7:0] = seq;
    return {e, s, {KW{1'b1}}, d};
  endfunction

  task automatic push0(input logic [EW-1:0] e);
    q0_mem[q0_wr % 64] = e;
    q0_wr++;
  endtask

  task automatic push1(input logic [EW-1:0] e);
    q1_mem[q1_wr % 64] = e;
    q1_wr++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_log(input int target, input int budget);
    int t;
    t = 0;
    while (log_n < target && t < budget) begin
      step(1);
      t++;
    end
    if (log_n < target) check_val("timeout", 64'(log_n), 64'(target));
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    enable = 1'b0;
    strict = 1'b0;
    ready  = 1'b1;
    clear  = 1'b0;
    q0_wr  = q0_rp;
    q1_wr  = q1_rp;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  initial begin
    int b;
    int n1;
    int r0;
    int exp_order [8];
    exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};

    rst = 1'b0; enable = 1'b0; strict = 1'b0; ready = 1'b1; clear = 1'b0;
    w0 = 8'd3; w1 = 8'd1;
    #1;
    check_val("rst_valid", 64'(tx_valid), 64'd0);
    check_val("rst_cnt0", 64'(cnt0), 64'd0);
    check_val("rst_sticky", 64'(sticky), 64'd0);
    step(1);
    rst = 1'b1;
    step(1);
    check_val("idle_valid", 64'(tx_valid), 64'd0);

    // Weights 3/1 with eight single-beat packets on each queue.
    for (int i = 0; i < 8; i++) begin
      push0(mk(1'b0, 8'(i), 1'b1, 1'b1));
      push1(mk(1'b1, 8'(i), 1'b1, 1'b1));
    end
    b = log_n;
    enable = 1'b1;
    wait_log(b + 16, 120);
    for (int i = 0; i < 8; i++) check_val($sformatf("wrr_order%0d", i), 64'(log_q[b+i]), 64'(exp_order[i]));
    check_val("wrr_cnt0", 64'(cnt0), 64'd8);
    check_val("wrr_cnt1", 64'(cnt1), 64'd8);
    check_val("wrr_sticky", 64'(sticky), 64'd0);

    // A four-beat NIC packet must not be interleaved with a P2P beat that arrives mid-packet.
    do_reset();
    for (int i = 0; i < 4; i++) push0(mk(1'b0, 8'(i), 1'(i == 0), 1'(i == 3)));
    b = log_n;
    enable = 1'b1;
    step(3);
    push1(mk(1'b1, 8'h50, 1'b1, 1'b1));
    wait_log(b + 5, 60);
    for (int i = 0; i < 4; i++) check_val($sformatf("atom_q%0d", i), 64'(log_q[b+i]), 64'd0);
    check_val("atom_contig", 64'(log_t[b+3] - log_t[b]), 64'd3);
    check_val("atom_p2p_q", 64'(log_q[b+4]), 64'd1);
    check_val("atom_p2p_seq", 64'(log_seq[b+4]), 64'h50);

    // Downstream stall of five cycles in the middle of a packet.
    do_reset();
    for (int i = 0; i < 6; i++) push0(mk(1'b0, 8'(i), 1'(i == 0), 1'(i == 5)));
    b = log_n;
    enable = 1'b1;
    wait_log(b + 2, 40);
    ready = 1'b0;
    r0 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_val($sformatf("stall_data%0d", i), 64'(tx_data[15:0]), 64'h0002);
    end
    check_val("stall_valid", 64'(tx_valid), 64'd1);
    check_val("stall_no_pop", 64'(rd_cnt - r0), 64'd0);
    ready = 1'b1;
    wait_log(b + 6, 40);
    for (int i = 0; i < 6; i++) check_val($sformatf("stall_seq%0d", i), 64'(log_seq[b+i]), 64'(i));
    check_val("stall_rate", 64'(log_t[b+5] - log_t[b+2]), 64'd3);
    step(5);
    check_val("stall_no_dup", 64'(log_n - b), 64'd6);
    check_val("stall_cnt0", 64'(cnt0), 64'd1);

    // Strict priority: queue 1 waits until queue 0 drains.
    do_reset();
    strict = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push0(mk(1'b0, 8'(i), 1'b1, 1'b1));
      push1(mk(1'b1, 8'(i), 1'b1, 1'b1));
    end
    b = log_n;
    enable = 1'b1;
    wait_log(b + 6, 60);
    n1 = 0;
    for (int i = 0; i < 6; i++) n1 += log_q[b+i];
    check_val("strict_q1_beats", 64'(n1), 64'd0);
    check_val("strict_cnt1_0", 64'(cnt1), 64'd0);
    check_val("strict_cnt0", 64'(cnt0), 64'd6);
    wait_log(b + 12, 60);
    check_val("strict_drain_q", 64'(log_q[b+6]), 64'd1);
    check_val("strict_cnt1", 64'(cnt1), 64'd6);

    // Framing errors and the synchronous clear.
    do_reset();
    push0(mk(1'b0, 8'h33, 1'b0, 1'b1));
    b = log_n;
    enable = 1'b1;
    wait_log(b + 1, 20);
    step(1);
    check_val("ferr_fwd", 64'(log_seq[b]), 64'h33);
    check_val("ferr_sticky", 64'(sticky), 64'd1);
    check_val("ferr_cnt0", 64'(cnt0), 64'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_val("clr_sticky", 64'(sticky), 64'd0);
    check_val("clr_cnt0", 64'(cnt0), 64'd0);
    check_val("clr_cnt1", 64'(cnt1), 64'd0);
    push0(mk(1'b0, 8'h40, 1'b1, 1'b0));
    push0(mk(1'b0, 8'h41, 1'b1, 1'b1));
    b = log_n;
    wait_log(b + 2, 20);
    step(1);
    check_val("ferr_mid_sticky", 64'(sticky), 64'd1);
    check_val("ferr_mid_seq", 64'(log_seq[b+1]), 64'h41);
    check_val("ferr_mid_cnt0", 64'(cnt0), 64'd1);

    // Asynchronous reset mid-packet, then the first grant goes to queue 0.
    do_reset();
    for (int i = 0; i < 4; i++) push0(mk(1'b0, 8'(i), 1'(i == 0), 1'(i == 3)));
    b = log_n;
    enable = 1'b1;
    wait_log(b + 2, 20);
    #3 rst = 1'b0;
    #1;
    check_val("arst_valid", 64'(tx_valid), 64'd0);
    check_val("arst_data", 64'(tx_data[63:0]), 64'd0);
    check_val("arst_rd", 64'({q0_rd, q1_rd}), 64'd0);
    enable = 1'b0;
    q0_wr  = q0_rp;
    q1_wr  = q1_rp;
    step(2);
    rst = 1'b1;
    step(1);
    push1(mk(1'b1, 8'h61, 1'b1, 1'b1));
    push0(mk(1'b0, 8'h60, 1'b1, 1'b1));
    b = log_n;
    enable = 1'b1;
    wait_log(b + 2, 20);
    check_val("arst_first_q", 64'(log_q[b]), 64'd0);
    check_val("arst_second_q", 64'(log_q[b+1]), 64'd1);

    check_val("one_rd_en", 64'(both_rd), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
